// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between two masters, round-robin with an m1 burst lock,
// one outstanding transaction at a time, aborted with an error flag on timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT  = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_rd_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_mask,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_rd_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_mask,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    input  logic        m1_lock,
    output logic        cs,
    output logic        mem_rd_wr,
    output logic [3:0]  mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_valid,
    output logic        owner,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t        state_q, state_d;
    logic          cs_q, cs_d, rd_wr_q, rd_wr_d, owner_q, owner_d, last_q, last_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          win, fin;
    logic [31:0]   rdata_v;
    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        rd_wr_d  = rd_wr_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tmo_d    = tmo_q;
        lock_d   = lock_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        win      = (last_q && m1_req && m1_lock && (!m0_req || lock_q < LW'(LOCK_MAX))) ? 1'b1 :
                   (m0_req && m1_req) ? !last_q : m1_req;
        fin      = mem_valid || tmo_q == TW'(TIMEOUT - 1);
        rdata_v  = (mem_valid && rd_wr_q) ? mem_read_data : '0;
        unique case (state_q)
            IDLE: if (m0_req || m1_req) begin
                state_d = ACCESS;
                cs_d    = 1'b1;
                owner_d = win;
                rd_wr_d = win ? m1_rd_wr : m0_rd_wr;
                mask_d  = win ? m1_mask : m0_mask;
                addr_d  = win ? m1_addr : m0_addr;
                wdata_d = win ? m1_wdata : m0_wdata;
                tmo_d   = '0;
                lock_d  = (win && m0_req) ? lock_q + 1'b1 : '0;
            end
            ACCESS: begin
                tmo_d = tmo_q + 1'b1;
                if (fin) begin
                    state_d = DONE;
                    cs_d    = 1'b0;
                    if (owner_q) begin
                        rdata1_d = rdata_v;
                        err1_d   = !mem_valid;
                    end else begin
                        rdata0_d = rdata_v;
                        err0_d   = !mem_valid;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cs_q     <= 1'b0;
            rd_wr_q  <= 1'b0;
            mask_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            tmo_q    <= '0;
            lock_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            rd_wr_q  <= rd_wr_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            tmo_q    <= tmo_d;
            lock_q   <= lock_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end
    assign cs             = cs_q;
    assign mem_rd_wr      = rd_wr_q;
    assign mask           = mask_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign owner          = owner_q;
    assign busy           = state_q != IDLE;
    assign m0_ack         = state_q == DONE && !owner_q;
    assign m1_ack         = state_q == DONE && owner_q;
    assign m0_rdata       = rdata0_q;
    assign m1_rdata       = rdata1_q;
    assign m0_err         = err0_q;
    assign m1_err         = err1_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, hand sequences and randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int TIMEOUT  = 16;
    localparam int LOCK_MAX = 4;
    logic        clk = 0, reset = 1;
    logic        m0_req = 0, m0_rd_wr = 0, m1_req = 0, m1_rd_wr = 0, m1_lock = 0, mem_valid = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, mem_read_data = 0;
    logic [3:0]  m0_mask = 0, m1_mask = 0;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_write_data;
    logic        m0_ack, m0_err, m1_ack, m1_err, cs, mem_rd_wr, owner, busy;
    logic [3:0]  mask;
    int          checks = 0, errors = 0;
    bit          lg = 1;
    int          lc = 0;
    logic [31:0] exp_rd[2] = '{0, 0};
    bit          exp_er[2] = '{0, 0};
    typedef struct {
        bit r0, r1, lk, rw0, rw1;
        int k;
        logic [31:0] a0, a1, rdv;
        bit w, err;
    } vec_t;
    vec_t tab[20];
    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rd_wr(m0_rd_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_rd_wr(m1_rd_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_lock(m1_lock),
        .cs(cs), .mem_rd_wr(mem_rd_wr), .mask(mask), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_valid(mem_valid), .owner(owner), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    // Winner chosen from the arbitration rules, using the model's last grant and lock count.
    function automatic bit model_win(input bit r0, input bit r1, input bit lk);
        if (lg && r1 && lk && (!r0 || lc < LOCK_MAX)) return 1'b1;
        if (r0 && r1) return !lg;
        return r1;
    endfunction
    // Starts in an IDLE cycle; ends in the following IDLE cycle with the loser's request still high.
    task automatic do_txn(input vec_t v);
        logic [31:0] wd0, wd1, rexp;
        logic [3:0]  mk0, mk1;
        bit          rw;
        wd0 = $urandom; wd1 = $urandom; mk0 = 4'($urandom); mk1 = 4'($urandom);
        m0_req = v.r0; m1_req = v.r1; m1_lock = v.lk;
        m0_rd_wr = v.rw0; m1_rd_wr = v.rw1; m0_addr = v.a0; m1_addr = v.a1;
        m0_wdata = wd0; m1_wdata = wd1; m0_mask = mk0; m1_mask = mk1;
        mem_valid = 1'($urandom); mem_read_data = $urandom;
        rw = v.w ? v.rw1 : v.rw0;
        step();
        chk("grant_cs", 32'(cs), 1);
        chk("grant_owner", 32'(owner), 32'(v.w));
        chk("grant_busy", 32'(busy), 1);
        chk("grant_rd_wr", 32'(mem_rd_wr), 32'(rw));
        chk("grant_addr", mem_addr, v.w ? v.a1 : v.a0);
        chk("grant_wdata", mem_write_data, v.w ? wd1 : wd0);
        chk("grant_mask", 32'(mask), 32'(v.w ? mk1 : mk0));
        m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
        m0_rd_wr = 1'($urandom); m1_rd_wr = 1'($urandom); m0_mask = 4'($urandom); m1_mask = 4'($urandom);
        for (int i = 1; i <= TIMEOUT; i++) begin
            mem_valid = (i == v.k);
            mem_read_data = (i == v.k) ? v.rdv : $urandom;
            step();
            if (i == v.k || i == TIMEOUT) break;
            chk("access_cs", 32'(cs), 1);
            chk("access_addr", mem_addr, v.w ? v.a1 : v.a0);
            chk("access_ack", {m1_ack, m0_ack}, 0);
        end
        mem_valid = 1'($urandom);
        mem_read_data = $urandom;
        rexp = (!v.err && rw) ? v.rdv : 32'h0;
        exp_rd[v.w] = rexp;
        exp_er[v.w] = v.err;
        chk("done_cs", 32'(cs), 0);
        chk("done_busy", 32'(busy), 1);
        chk("done_ack", {m1_ack, m0_ack}, v.w ? 2 : 1);
        chk("done_rdata0", m0_rdata, exp_rd[0]);
        chk("done_rdata1", m1_rdata, exp_rd[1]);
        chk("done_err", {m1_err, m0_err}, {exp_er[1], exp_er[0]});
        if (v.w) m1_req = 0; else m0_req = 0;
        lc = (v.w && v.r0) ? lc + 1 : 0;
        lg = v.w;
        step();
        mem_valid = 0;
        chk("idle_ack", {m1_ack, m0_ack}, 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_hold", m0_rdata ^ m1_rdata, exp_rd[0] ^ exp_rd[1]);
    endtask
    initial begin
        vec_t v;
        bit   p0, p1;
        tab[0]  = '{1, 1, 0, 1, 1, 2,  32'h0000_1000, 32'h0000_2000, 32'h1111_1111, 0, 0};
        tab[1]  = '{0, 1, 0, 1, 1, 3,  32'h0000_1004, 32'h0000_2004, 32'h2222_2222, 1, 0};
        tab[2]  = '{1, 1, 0, 1, 0, 1,  32'h0000_1008, 32'h0000_2008, 32'h3333_3333, 0, 0};
        tab[3]  = '{1, 1, 0, 0, 1, 1,  32'h0000_100C, 32'h0000_200C, 32'h4444_4444, 1, 0};
        tab[4]  = '{1, 1, 0, 0, 0, 1,  32'h0000_1010, 32'h0000_2010, 32'h5555_5555, 0, 0};
        tab[5]  = '{1, 1, 0, 1, 1, 1,  32'h0000_1014, 32'h0000_2014, 32'h6666_6666, 1, 0};
        tab[6]  = '{1, 1, 0, 1, 1, 1,  32'h0000_1018, 32'h0000_2018, 32'h7777_7777, 0, 0};
        tab[7]  = '{1, 1, 1, 1, 1, 1,  32'h0000_101C, 32'h0000_201C, 32'h8888_8888, 1, 0};
        tab[8]  = '{1, 1, 1, 1, 1, 1,  32'h0000_1020, 32'h0000_2020, 32'h9999_9999, 1, 0};
        tab[9]  = '{1, 1, 1, 1, 1, 2,  32'h0000_1024, 32'h0000_2024, 32'hAAAA_AAAA, 1, 0};
        tab[10] = '{1, 1, 1, 1, 1, 1,  32'h0000_1028, 32'h0000_2028, 32'hBBBB_BBBB, 1, 0};
        tab[11] = '{1, 1, 1, 1, 1, 1,  32'h0000_102C, 32'h0000_202C, 32'hCCCC_CCCC, 0, 0};
        tab[12] = '{1, 1, 1, 1, 1, 1,  32'h0000_1030, 32'h0000_2030, 32'hDDDD_DDDD, 1, 0};
        tab[13] = '{0, 1, 1, 1, 1, 1,  32'h0000_1034, 32'h0000_2034, 32'hEEEE_EEEE, 1, 0};
        tab[14] = '{0, 1, 1, 1, 1, 1,  32'h0000_1038, 32'h0000_2038, 32'h1234_5678, 1, 0};
        tab[15] = '{0, 1, 1, 1, 1, 1,  32'h0000_103C, 32'h0000_203C, 32'h8765_4321, 1, 0};
        tab[16] = '{0, 1, 0, 1, 0, 20, 32'h0000_1040, 32'h2000_0000, 32'hFFFF_FFFF, 1, 1};
        tab[17] = '{1, 0, 0, 1, 1, 1,  32'h0000_1044, 32'h0000_2044, 32'h0BAD_CAFE, 0, 0};
        tab[18] = '{0, 1, 0, 1, 1, 16, 32'h0000_1048, 32'h0000_2048, 32'hCAFE_F00D, 1, 0};
        tab[19] = '{1, 0, 0, 1, 1, 2,  32'h0000_0100, 32'h0000_204C, 32'hDEAD_BEEF, 0, 0};
        step();
        step();
        chk("rst_cs_busy_owner", {cs, busy, owner, mem_rd_wr}, 0);
        chk("rst_mem", {mask, mem_addr[27:0]} | mem_write_data, 0);
        chk("rst_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rst_rdata", m0_rdata | m1_rdata, 0);
        reset = 0;
        step();
        for (int i = 0; i < 20; i++) do_txn(tab[i]);
        chk("single_read_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 0; m1_req = 1; m1_lock = 0; m1_rd_wr = 1; m1_addr = 32'h0000_3000;
        step();
        chk("mid_grant_owner", 32'(owner), 1);
        step();
        step();
        reset = 1;
        step();
        reset = 0; m1_req = 0; mem_valid = 1; mem_read_data = 32'h5A5A_5A5A;
        chk("mid_rst_cs_busy_owner", {cs, busy, owner}, 0);
        chk("mid_rst_ack", {m0_ack, m1_ack}, 0);
        chk("mid_rst_rdata", m0_rdata | m1_rdata, 0);
        step();
        mem_valid = 0;
        chk("late_valid_ack", {m0_ack, m1_ack, busy, cs}, 0);
        step();
        chk("late_valid_ack2", {m0_ack, m1_ack, busy, cs, m1_err}, 0);
        lg = 1; lc = 0; exp_rd = '{0, 0}; exp_er = '{0, 0};
        v = '{1, 1, 0, 1, 1, 1, 32'h0000_4000, 32'h0000_5000, 32'h0F0F_0F0F, 0, 0};
        v.w = model_win(v.r0, v.r1, v.lk);
        chk("post_rst_contention", 32'(v.w), 0);
        do_txn(v);
        p0 = 0; p1 = 1;
        for (int n = 0; n < 300; n++) begin
            v.r0 = p0 | 1'($urandom);
            v.r1 = p1 | 1'($urandom);
            if (!v.r0 && !v.r1) begin
                v.r0 = 1'($urandom);
                v.r1 = !v.r0;
            end
            v.lk = 1'($urandom);
            v.rw0 = 1'($urandom); v.rw1 = 1'($urandom);
            v.a0 = $urandom; v.a1 = $urandom; v.rdv = $urandom;
            v.k = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 4);
            v.err = v.k > TIMEOUT;
            v.w = model_win(v.r0, v.r1, v.lk);
            p0 = v.w ? v.r0 : 1'b0;
            p1 = v.w ? 1'b0 : v.r1;
            do_txn(v);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (cs / mem_rd_wr / mask / addr / write data / read data / mem_valid) between two masters.
  - Master 0: the CPU load/store path.
  - Master 1: the GEMM accelerator's operand/result DMA.
- Arbitration is round-robin, with a bounded burst lock for the accelerator.
- Exactly one transaction is outstanding at a time; each transaction has a timeout.
- Sits between the core's memory-stage port and the memory/peripheral bus.

Parameters:
- TIMEOUT, 16, cycles in ACCESS without mem_valid before the transaction is aborted with error.
- LOCK_MAX, 4, maximum consecutive master-1 grants under m1_lock while master 0 is requesting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 transaction request; level, held until m0_ack.
- m0_rd_wr  in  1  1 = read, 0 = write.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  write data.
- m0_mask  in  4  byte-lane mask.
- m0_rdata  out  32  read data, valid with m0_ack.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  timeout flag, valid with m0_ack.
- m1_req, m1_rd_wr, m1_addr, m1_wdata, m1_mask, m1_rdata, m1_ack, m1_err  same as master 0.
- m1_lock  in  1  master 1 requests to keep the port for its next beat.
- cs  out  1  memory chip select.
- mem_rd_wr  out  1  1 = read.
- mask  out  4  byte mask to memory.
- mem_addr  out  32  address to memory.
- mem_write_data  out  32  write data to memory.
- mem_read_data  in  32  read data from memory.
- mem_valid  in  1  memory completion.
- owner  out  1  index of the currently granted master.
- busy  out  1  high in ACCESS or DONE.

Behaviour:
- Reset:
  - State IDLE; cs = 0, all mem_* outputs = 0.
  - m*_ack = 0, m*_err = 0, m*_rdata = 0.
  - owner = 0, busy = 0.
  - last_grant = 1, so master 0 wins the first contention.
  - lock_cnt = 0, timeout counter = 0.
  - Reset asserted mid-transaction drops it silently: no ack is issued, cs falls on the next edge.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any request is pending at the clock edge, select a winner.
  - Register the winner's rd_wr/addr/wdata/mask into the mem_* outputs, set cs = 1 and owner, and go to ACCESS.
  - Payload is latched once at grant; requester changes after grant are ignored.
- Winner selection (priority order):
  1. Lock: if last_grant == 1, m1_req & m1_lock, and (!m0_req or lock_cnt < LOCK_MAX), master 1 wins.
  2. Otherwise, only one requester: it wins.
  3. Both requesting: the master != last_grant wins.
- lock_cnt update on each grant:
  - Increments on each master-1 grant taken while m0_req is high.
  - Clears on any master-0 grant.
  - Clears on a master-1 grant taken while m0_req is low.
- ACCESS:
  - cs is held; the timeout counter increments each cycle.
  - mem_valid = 1:
    - cs drops on that edge.
    - For reads, mem_read_data is captured into the owner's rdata; for writes, rdata = 0.
    - err = 0; go to DONE.
  - Counter reaches TIMEOUT - 1 without mem_valid: cs drops, rdata = 0, err = 1, go to DONE.
  - mem_valid arriving in any state other than ACCESS is ignored.
- DONE:
  - The owner's ack = 1 for exactly one cycle; last_grant = owner; go to IDLE.
  - The non-owner's ack is never asserted.
- Requester rule: req must be deasserted in the ack cycle. If it is still high in the following IDLE cycle, that is a new transaction.
- Latency:
  - Request sampled at edge N: cs high from N+1.
  - mem_valid sampled at edge N+k: ack high during cycle N+k+1.
  - Minimum 3 cycles per transaction (mem_valid on the first ACCESS cycle).
- rdata/err hold their values after ack until the next completion for that master.

Test Plan:
- Single read: m0 read addr 0x100, mem returns 0xDEADBEEF with mem_valid 2 cycles after cs -> cs=1 rd_wr=1 addr=0x100; m0_ack pulse with rdata=0xDEADBEEF, err=0; m1_ack stays 0.
- Contention after reset: m0 and m1 request together at the same cycle -> m0 served first; m1 granted in the IDLE cycle right after m0's ack; owner sequence 0, 1.
- Round-robin: both masters request continuously for 6 transactions, mem_valid immediate -> owner alternates 1,0,1,0,... after the first m0 grant; each transaction takes 3 cycles.
- Lock limit: m1_lock=1 with both masters requesting continuously, LOCK_MAX=4 -> after the first m0 grant, exactly 4 consecutive m1 grants, then m0, then lock_cnt cleared; with m0_req=0 throughout, m1 keeps the port indefinitely.
- Timeout: m1 write to 0x2000_0000, mem_valid never asserted -> cs high for exactly 16 cycles, then m1_ack with m1_err=1 and rdata=0; the next request proceeds normally.
- Reset mid-access: reset during ACCESS -> next cycle cs=0, busy=0, owner=0, no ack; a late mem_valid is ignored; the first post-reset contention grants m0.
